// File: rtl/ixayoi_axil_ram.sv
// AXI4-Lite responder over a word-addressed on-chip RAM with byte-strobe writes.
// Independent write (AW/W/B) and read (AR/R) paths, one outstanding transaction each.
module ixayoi_axil_ram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp
);

  localparam int                    IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH  = ADDR_WIDTH'(MEM_WORDS);
  localparam logic [1:0]            OKAY   = 2'b00;
  localparam logic [1:0]            SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [31:0] mem [MEM_WORDS];

  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  logic                  aw_in, ar_in;
  logic [IDX_W-1:0]      aw_word;
  logic                  aw_ok;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic                  aw_fire, w_fire;

  // Offsets wrap modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR fall out of range.
  assign aw_off  = s_axi_awaddr - BASE_ADDR;
  assign ar_off  = s_axi_araddr - BASE_ADDR;
  assign aw_in   = (aw_off >> 2) < DEPTH;
  assign ar_in   = (ar_off >> 2) < DEPTH;
  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;

  // awready/wready double as the "holding register empty" flags while in W_IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= OKAY;
      aw_word       <= '0;
      aw_ok         <= 1'b0;
      w_data        <= '0;
      w_strb        <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            s_axi_awready <= 1'b0;
            aw_word       <= aw_off[IDX_W+1:2];
            aw_ok         <= aw_in;
          end
          if (w_fire) begin
            s_axi_wready <= 1'b0;
            w_data       <= s_axi_wdata;
            w_strb       <= s_axi_wstrb;
          end
          if ((!s_axi_awready || aw_fire) && (!s_axi_wready || w_fire))
            w_state <= W_COMMIT;
        end
        W_COMMIT: begin
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= aw_ok ? OKAY : SLVERR;
          w_state      <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM contents survive reset; a commit coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (!reset && w_state == W_COMMIT && aw_ok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[aw_word][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= ar_in ? mem[ar_off[IDX_W+1:2]] : '0;
            s_axi_rresp   <= ar_in ? OKAY : SLVERR;
            r_state       <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
